// File: rtl/mem_pkg.sv
// mem_pkg: access-size codes, clear FSM states and byte-lane helpers for dmem_bytelane.
package mem_pkg;
    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic {CLEAR, RUN} clr_state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return size == SZ_B ? 3'd1 : size == SZ_H ? 3'd2 : size == SZ_W ? 3'd4 : 3'd0;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [1:0] size);
        return size == SZ_B ? 4'b0001 << a : size == SZ_H ? 4'b0011 << a :
               size == SZ_W ? 4'b1111 : 4'b0000;
    endfunction
endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: one 8-bit byte lane, 1R1W with registered read and write enable.
module dmem_lane #(
    parameter int WORDS = 344,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    q
);
    logic [7:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 8'h00;
        else if (re) q <= r_mem[raddr];
    end
endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressed data memory with sized access, faults,
// write-first forwarding and an optional post-reset clear sequencer.
module dmem_bytelane
    import mem_pkg::*;
#(
    parameter int DEPTH          = 1376,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [31:0] raddr,
    input  logic [1:0]  rsize,
    input  logic        rsigned,
    output logic [31:0] out,
    output logic        out_valid,
    output logic        rfault,
    input  logic        memwr,
    input  logic [31:0] waddr,
    input  logic [1:0]  wsize,
    input  logic [31:0] in,
    output logic        wfault,
    output logic        busy
);
    localparam int WORDS = DEPTH / 4;
    localparam int AW    = WORDS > 1 ? $clog2(WORDS) : 1;

    function automatic logic fault(input logic [31:0] a, input logic [1:0] s);
        return s == SZ_RSV || (s == SZ_H && a[0]) || (s == SZ_W && a[1:0] != 2'b00) ||
               ({1'b0, a} + {30'b0, size_bytes(s)} - 33'd1 >= 33'(DEPTH));
    endfunction

    clr_state_t       r_state;
    logic             r_busy;
    logic [AW-1:0]    r_cnt;
    logic             r_valid, r_rf, r_wf, r_sg;
    logic [3:0]       r_fwd;
    logic [31:0]      r_fbyte;
    logic [1:0]       r_ra, r_rs;
    logic             w_rf_now, w_wf_now, w_rd_acc, w_wr_ok;
    logic [3:0]       w_wm;
    logic [31:0]      w_wdata, w_word, w_sh, w_ext;
    logic [AW-1:0]    w_ridx, w_widx;
    logic [3:0][7:0]  w_q;

    assign w_rf_now = fault(raddr, rsize);
    assign w_wf_now = fault(waddr, wsize);
    assign w_rd_acc = rd_en & ~r_busy;
    assign w_wr_ok  = memwr & ~r_busy & ~w_wf_now;
    assign w_wm     = lane_mask(waddr[1:0], wsize);
    assign w_ridx   = raddr[AW+1:2];
    assign w_widx   = waddr[AW+1:2];
    // Accesses are aligned, so a plain shift places byte k of in at lane addr+k.
    assign w_wdata  = in << {waddr[1:0], 3'b000};

    for (genvar j = 0; j < 4; j++) begin : g_lane
        dmem_lane #(.WORDS(WORDS), .AW(AW)) u_lane (
            .clk(clk),
            .rst(rst),
            .we(r_busy | (w_wr_ok & w_wm[j])),
            .waddr(r_busy ? r_cnt : w_widx),
            .wdata(r_busy ? 8'h00 : w_wdata[8*j +: 8]),
            .re(w_rd_acc & ~w_rf_now),
            .raddr(w_ridx),
            .q(w_q[j])
        );
        assign w_word[8*j +: 8] = r_fwd[j] ? r_fbyte[8*j +: 8] : w_q[j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? CLEAR : RUN;
            r_busy  <= CLEAR_ON_RESET;
            r_cnt   <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == AW'(WORDS - 1)) begin
                r_state <= RUN;
                r_busy  <= 1'b0;
            end
        end
    end

    // Read metadata and forwarded bytes only move on an accepted read, so out holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rf    <= 1'b0;
            r_wf    <= 1'b0;
            r_fwd   <= 4'b0;
            r_fbyte <= 32'h0;
            r_ra    <= 2'b00;
            r_rs    <= SZ_B;
            r_sg    <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
            r_wf    <= memwr & ~r_busy & w_wf_now;
            if (w_rd_acc) begin
                r_rf    <= w_rf_now;
                r_fwd   <= (w_wr_ok && w_widx == w_ridx) ? w_wm : 4'b0;
                r_fbyte <= w_wdata;
                r_ra    <= raddr[1:0];
                r_rs    <= rsize;
                r_sg    <= rsigned;
            end
        end
    end

    assign w_sh  = w_word >> {r_ra, 3'b000};
    assign w_ext = r_rs == SZ_B ? {{24{r_sg & w_sh[7]}}, w_sh[7:0]} :
                   r_rs == SZ_H ? {{16{r_sg & w_sh[15]}}, w_sh[15:0]} : w_word;

    assign out       = r_rf ? 32'h0 : w_ext;
    assign out_valid = r_valid;
    assign rfault    = r_valid & r_rf;
    assign wfault    = r_wf;
    assign busy      = r_busy;
endmodule
